// File: rtl/wt_mem_arbiter.sv
// N-port round-robin request arbiter with tagged return routing and per-port outstanding limits.
// Latency: request acked in the same cycle, slot valid next cycle; returns routed combinationally.
// Backpressure: slot holds while mem_ack_i is low; ports beyond MaxOutstanding are masked. `WT_MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module wt_mem_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned RtrnWidth      = 256,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned PortIdWidth    = $clog2(NumPorts)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumPorts-1:0]                port_req_i,
    output logic [NumPorts-1:0]                port_ack_o,
    input  logic [NumPorts-1:0][ReqWidth-1:0]  port_data_i,
    output logic [NumPorts-1:0]                port_rtrn_vld_o,
    output logic [RtrnWidth-1:0]               port_rtrn_o,
    output logic                               mem_req_o,
    input  logic                               mem_ack_i,
    output logic [ReqWidth-1:0]                mem_data_o,
    output logic [PortIdWidth-1:0]             mem_port_o,
    input  logic                               mem_rtrn_vld_i,
    input  logic [PortIdWidth-1:0]             mem_rtrn_port_i,
    input  logic [RtrnWidth-1:0]               mem_rtrn_i,
    output logic                               idle_o,
    output logic                               err_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    typedef logic [CntWidth-1:0] cnt_t;

    cnt_t                   cnt_q [NumPorts];
    logic                   slot_vld_q;
    logic [ReqWidth-1:0]    slot_dat_q;
    logic [PortIdWidth-1:0] slot_port_q;
    logic                   err_q;

    logic [NumPorts-1:0]    elig;
    logic [NumPorts-1:0]    grant;
    logic [NumPorts-1:0]    hit;
    logic                   win_found;
    logic [PortIdWidth-1:0] win_idx;
    logic                   grant_en;
    logic                   rtrn_bad;
    logic                   idle;

    // A same-cycle return does not free a slot for eligibility; the limit uses registered counts only.
    always_comb begin
        elig = '0;
        for (int p = 0; p < NumPorts; p++) begin
            elig[p] = port_req_i[p] && (cnt_q[p] < cnt_t'(MaxOutstanding));
        end
    end

`ifdef WT_MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!win_found && elig[PortIdWidth'(i)]) begin
                win_found = 1'b1;
                win_idx   = PortIdWidth'(i);
            end
        end
    end
`else
    logic [PortIdWidth-1:0] ptr_q;

    always_comb begin
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= NumPorts; i++) begin
            cand = (int'(ptr_q) + i) % NumPorts;
            if (!win_found && elig[PortIdWidth'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PortIdWidth'(cand);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PortIdWidth'(NumPorts - 1);
        end else if (grant_en) begin
            ptr_q <= win_idx;
        end
    end
`endif

    // Gating on rst_ni keeps acks low while reset is held, even with requests pending.
    assign grant_en = rst_ni && (!slot_vld_q || mem_ack_i) && win_found;

    always_comb begin
        grant = '0;
        hit   = '0;
        for (int p = 0; p < NumPorts; p++) begin
            grant[p] = grant_en && (win_idx == PortIdWidth'(p));
            hit[p]   = mem_rtrn_vld_i && (mem_rtrn_port_i == PortIdWidth'(p)) && (cnt_q[p] != '0);
        end
    end

    // Out-of-range tags match no port, so they fall into the error case along with unexpected returns.
    assign rtrn_bad = mem_rtrn_vld_i && !(|hit);

    always_comb begin
        idle = !slot_vld_q;
        for (int p = 0; p < NumPorts; p++) begin
            if (cnt_q[p] != '0) begin
                idle = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_vld_q  <= 1'b0;
            slot_dat_q  <= '0;
            slot_port_q <= '0;
            err_q       <= 1'b0;
            for (int p = 0; p < NumPorts; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            if (grant_en) begin
                slot_vld_q  <= 1'b1;
                slot_dat_q  <= port_data_i[win_idx];
                slot_port_q <= win_idx;
            end else if (mem_ack_i) begin
                slot_vld_q  <= 1'b0;
            end
            for (int p = 0; p < NumPorts; p++) begin
                cnt_q[p] <= cnt_q[p] + cnt_t'(grant[p]) - cnt_t'(hit[p]);
            end
            if (rtrn_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign port_ack_o      = grant;
    assign port_rtrn_vld_o = hit;
    assign port_rtrn_o     = (|hit) ? mem_rtrn_i : '0;
    assign mem_req_o       = slot_vld_q;
    assign mem_data_o      = slot_dat_q;
    assign mem_port_o      = slot_port_q;
    assign idle_o          = idle;
    assign err_o           = err_q;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Self-checking bench for wt_mem_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_wt_mem_arbiter;

    localparam int NP   = 3;
    localparam int RW   = 16;
    localparam int TW   = 16;
    localparam int MAXO = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NP-1:0]          port_req;
    logic [NP-1:0]          port_ack;
    logic [NP-1:0][RW-1:0]  port_data;
    logic [NP-1:0]          port_rtrn_vld;
    logic [TW-1:0]          port_rtrn;
    logic                   mem_req;
    logic                   mem_ack;
    logic [RW-1:0]          mem_data;
    logic [1:0]             mem_port;
    logic                   rtrn_vld;
    logic [1:0]             rtrn_port;
    logic [TW-1:0]          rtrn_dat;
    logic                   idle;
    logic                   err;

    always #5 clk = ~clk;

    wt_mem_arbiter #(
        .NumPorts(NP), .ReqWidth(RW), .RtrnWidth(TW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .port_req_i(port_req), .port_ack_o(port_ack), .port_data_i(port_data),
        .port_rtrn_vld_o(port_rtrn_vld), .port_rtrn_o(port_rtrn),
        .mem_req_o(mem_req), .mem_ack_i(mem_ack), .mem_data_o(mem_data), .mem_port_o(mem_port),
        .mem_rtrn_vld_i(rtrn_vld), .mem_rtrn_port_i(rtrn_port), .mem_rtrn_i(rtrn_dat),
        .idle_o(idle), .err_o(err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: outstanding counts, last winner, slot contents, sticky error.
    int            m_cnt [NP];
    int            m_ptr;
    bit            m_vld;
    logic [RW-1:0] m_dat;
    int            m_port;
    bit            m_err;
    int            last_win;
    logic [NP-1:0] last_ack;
    logic [NP-1:0] obs_ack;
    logic [NP-1:0] obs_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
        m_ptr = NP - 1;
        m_vld = 1'b0;
        m_dat = '0;
        m_port = 0;
        m_err = 1'b0;
        last_win = -1;
        last_ack = '0;
    endtask

    task automatic check_reset_vals();
        chk("rst_ack",   32'(port_ack),      32'd0);
        chk("rst_rv",    32'(port_rtrn_vld), 32'd0);
        chk("rst_rtrn",  32'(port_rtrn),     32'd0);
        chk("rst_req",   32'(mem_req),       32'd0);
        chk("rst_data",  32'(mem_data),      32'd0);
        chk("rst_port",  32'(mem_port),      32'd0);
        chk("rst_idle",  32'(idle),          32'd1);
        chk("rst_err",   32'(err),           32'd0);
    endtask

    task automatic clear_inputs();
        port_req = '0;
        port_data = '0;
        mem_ack = 1'b0;
        rtrn_vld = 1'b0;
        rtrn_port = '0;
        rtrn_dat = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        model_reset();
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Compare DUT outputs against the model mid-cycle, then advance the model past the coming edge.
    task automatic eval();
        logic [NP-1:0] e_ack, e_rv;
        int w, t;
        bit can, bad, idle_e;
        w = -1;
        can = !m_vld || mem_ack;
        if (can) begin
            for (int k = 0; k < NP; k++) begin
                int p;
`ifdef WT_MEM_ARB_FIXED_PRIO_EN
                p = k;
`else
                p = (m_ptr + 1 + k) % NP;
`endif
                if (w < 0 && port_req[p] && m_cnt[p] < MAXO) w = p;
            end
        end
        e_ack = '0;
        if (w >= 0) e_ack[w] = 1'b1;
        e_rv = '0;
        bad = 1'b0;
        t = int'(rtrn_port);
        if (rtrn_vld) begin
            if (t < NP && m_cnt[t] > 0) e_rv[t] = 1'b1;
            else bad = 1'b1;
        end
        idle_e = !m_vld;
        for (int p = 0; p < NP; p++) if (m_cnt[p] != 0) idle_e = 1'b0;

        obs_ack = port_ack;
        obs_rv = port_rtrn_vld;
        chk("ack",     32'(port_ack),      32'(e_ack));
        chk("rtrn_vld",32'(port_rtrn_vld), 32'(e_rv));
        if (e_rv != '0) chk("rtrn_dat", 32'(port_rtrn), 32'(rtrn_dat));
        chk("mem_req", 32'(mem_req),       32'(m_vld));
        if (m_vld) begin
            chk("mem_data", 32'(mem_data), 32'(m_dat));
            chk("mem_port", 32'(mem_port), 32'(m_port));
        end
        chk("idle",    32'(idle),          32'(idle_e));
        chk("err",     32'(err),           32'(m_err));

        if (w >= 0) begin
            m_vld = 1'b1;
            m_dat = port_data[w];
            m_port = w;
            m_cnt[w]++;
            m_ptr = w;
        end else if (mem_ack) begin
            m_vld = 1'b0;
        end
        if (e_rv != '0) m_cnt[t]--;
        if (bad) m_err = 1'b1;
        last_win = w;
        last_ack = e_ack;
    endtask

    task automatic cycle();
        @(negedge clk);
        eval();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();

        // Single request into an empty slot.
        do_reset();
        port_req = 3'b010;
        port_data[1] = 16'h00A5;
        cycle();
        chk("t1_ack", 32'(obs_ack), 32'b010);
        port_req = '0;
        chk("t1_mem_req",  32'(mem_req),  32'd1);
        chk("t1_mem_data", 32'(mem_data), 32'h00A5);
        chk("t1_mem_port", 32'(mem_port), 32'd1);
        chk("t1_idle",     32'(idle),     32'd0);
        cycle();

        // All ports requesting with returns keeping counts low.
        do_reset();
        mem_ack = 1'b1;
        port_req = 3'b111;
        for (int p = 0; p < NP; p++) port_data[p] = 16'(16'h0100 + p);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                rtrn_vld = 1'b1;
                rtrn_port = 2'(last_win);
                rtrn_dat = 16'(16'hB000 + c);
            end
            cycle();
`ifdef WT_MEM_ARB_FIXED_PRIO_EN
            chk("rr_win", 32'(last_win), 32'd0);
`else
            chk("rr_win", 32'(last_win), 32'(c % 3));
`endif
        end
        rtrn_vld = 1'b0;

        // Backpressure holds the slot and blocks further grants.
        do_reset();
        port_req = 3'b111;
        for (int p = 0; p < NP; p++) port_data[p] = 16'(16'h0100 + p);
        cycle();
        chk("bp_first", 32'(obs_ack), 32'b001);
        port_req[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("bp_noack", 32'(obs_ack),  32'd0);
            chk("bp_data",  32'(mem_data), 32'h0100);
            chk("bp_port",  32'(mem_port), 32'd0);
        end
        mem_ack = 1'b1;
        cycle();
        chk("bp_release", 32'(obs_ack), 32'b010);

        // Outstanding limit.
        do_reset();
        mem_ack = 1'b1;
        port_req = 3'b001;
        cycle(); chk("lim_c0", 32'(obs_ack), 32'b001);
        cycle(); chk("lim_c1", 32'(obs_ack), 32'b001);
        port_req = 3'b011;
        cycle(); chk("lim_c2", 32'(obs_ack), 32'b010);
        cycle(); chk("lim_c3", 32'(obs_ack), 32'b010);
        rtrn_vld = 1'b1; rtrn_port = 2'd0; rtrn_dat = 16'hC0DE;
        cycle();
        chk("lim_nobypass", 32'(obs_ack), 32'b000);
        chk("lim_rv",       32'(obs_rv),  32'b001);
        rtrn_vld = 1'b0;
        cycle(); chk("lim_freed", 32'(obs_ack), 32'b001);

        // Grant and return to the same port in one cycle.
        do_reset();
        mem_ack = 1'b1;
        port_req = 3'b001;
        cycle();
        rtrn_vld = 1'b1; rtrn_port = 2'd0; rtrn_dat = 16'h1234;
        cycle();
        chk("sim_ack", 32'(obs_ack), 32'b001);
        chk("sim_rv",  32'(obs_rv),  32'b001);
        rtrn_vld = 1'b0;
        cycle(); chk("sim_cnt1", 32'(obs_ack), 32'b001);
        cycle(); chk("sim_cnt2", 32'(obs_ack), 32'b000);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (last_ack[p]) begin
                    port_req[p] = 1'($urandom_range(0, 1));
                    port_data[p] = 16'($urandom);
                end else if (!port_req[p] && $urandom_range(0, 2) == 0) begin
                    port_req[p] = 1'b1;
                    port_data[p] = 16'($urandom);
                end
            end
            mem_ack = ($urandom_range(0, 3) != 0);
            begin
                int rp;
                rp = $urandom_range(0, NP - 1);
                rtrn_vld = (m_cnt[rp] > 0) && ($urandom_range(0, 1) == 1);
                rtrn_port = 2'(rp);
                rtrn_dat = 16'($urandom);
            end
            cycle();
        end
        clear_inputs();

        // Reset during traffic discards state; stale returns then flag an error.
        port_req = 3'b111;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals();
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rtrn_vld = 1'b1; rtrn_port = 2'd0; rtrn_dat = 16'hDEAD;
        cycle();
        chk("stale_rv", 32'(obs_rv), 32'd0);
        rtrn_vld = 1'b0;
        chk("stale_err", 32'(err), 32'd1);

        // Out-of-range tag and sticky error.
        do_reset();
        rtrn_vld = 1'b1; rtrn_port = 2'd3; rtrn_dat = 16'hBEEF;
        cycle();
        chk("err_rv", 32'(obs_rv), 32'd0);
        rtrn_vld = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("err_sticky", 32'(err), 32'd1);
        end
        do_reset();
        rtrn_vld = 1'b1; rtrn_port = 2'd1;
        cycle();
        rtrn_vld = 1'b0;
        chk("err_zero_cnt", 32'(err), 32'd1);
        do_reset();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wt_mem_arbiter.md
# wt_mem_arbiter

Parametrised N-port request arbiter and return router for the write-through cache subsystem, replacing the fixed two-client (I$/D$) plumbing in front of the memory adapter. It accepts held-until-acked requests from `NumPorts` cache clients, round-robin arbitrates them into a single registered request slot toward the AXI/L1.5 adapter, and tags each request with its port index. It routes tagged returns back to the owning client and enforces a per-port outstanding-transaction limit.

## Interface
- `NumPorts`, 2: number of client ports, ≥2.
- `ReqWidth`, 128: width of the opaque request payload.
- `RtrnWidth`, 256: width of the opaque return payload.
- `MaxOutstanding`, 4: maximum in-flight transactions per port, ≥1.
- `PortIdWidth`, `$clog2(NumPorts)`: width of the port tag (derived; not overridden).

- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `port_req_i`  in  NumPorts  request valid per port; held until acked.
- `port_ack_o`  out  NumPorts  one-hot acceptance per port.
- `port_data_i`  in  NumPorts×ReqWidth  request payload per port.
- `port_rtrn_vld_o`  out  NumPorts  one-hot return strobe; no backpressure.
- `port_rtrn_o`  out  RtrnWidth  return payload, broadcast to all ports.
- `mem_req_o`  out  1  slot valid toward the adapter.
- `mem_ack_i`  in  1  adapter accepts the slot.
- `mem_data_o`  out  ReqWidth  slot payload.
- `mem_port_o`  out  PortIdWidth  slot port tag.
- `mem_rtrn_vld_i`  in  1  return valid.
- `mem_rtrn_port_i`  in  PortIdWidth  return port tag.
- `mem_rtrn_i`  in  RtrnWidth  return payload.
- `idle_o`  out  1  slot empty and all outstanding counters zero.
- `err_o`  out  1  sticky protocol error.

## Operation
- Eligible port p: `port_req_i[p]` is high and `cnt[p] < MaxOutstanding`. A same-cycle return to p does not bypass the limit.
- Slot can load when it is empty, or when `mem_req_o && mem_ack_i` occur in the same cycle.
- Round-robin: the search starts at `ptr+1` and wraps from `NumPorts-1` to 0. The winner gets `port_ack_o`. `ptr` is set to the winner only on a grant.
- On a grant, the slot captures `port_data_i[winner]` and the winner index, and `cnt[winner]` increments. Counting happens at acceptance, so the slot contents count as in-flight.
- Slot payload and tag are stable while `mem_req_o && !mem_ack_i`.
- Return handling:
  - When `mem_rtrn_vld_i` is high and the tag q < NumPorts with `cnt[q] > 0`: `port_rtrn_vld_o[q]` is high in the same cycle and `cnt[q]` decrements.
  - Tag ≥ NumPorts, or `cnt[q] == 0`: the return is dropped (no strobe, no decrement) and `err_o` is set.
- Grant to p and return to p in the same cycle: `cnt[p]` is unchanged.
- Counter width is `$clog2(MaxOutstanding+1)`. It never wraps; increment is impossible at the limit by eligibility.

## Timing
- Reset values:
  - `port_ack_o` = 0, `port_rtrn_vld_o` = 0, `port_rtrn_o` = 0.
  - `mem_req_o` = 0, `mem_data_o` = 0, `mem_port_o` = 0.
  - `idle_o` = 1, `err_o` = 0.
  - `ptr` = `NumPorts-1`, so port 0 wins first. All `cnt` = 0.
- `port_ack_o` is combinational from `port_req_i`, `cnt`, slot state and `mem_ack_i`. Request at cycle 0 into an empty slot → ack at cycle 0, `mem_req_o` at cycle 1.
- Sustained throughput is one request per cycle when `mem_ack_i` is held high.
- Return path is purely combinational: `mem_rtrn_vld_i` → `port_rtrn_vld_o` in 0 cycles. Counter updates at the next edge.
- `idle_o` is registered-state derived, with no combinational path from inputs.
- `err_o` is set at the edge after the offending return and is cleared only by reset.
- Reset asserted mid-transaction discards the slot and counters immediately. Returns arriving after reset for pre-reset requests set `err_o`.

## Configuration
- `WT_MEM_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest-index eligible port wins and `ptr` is unused (tie it off).
- Undefined: round-robin as described. All other behaviour is identical in both builds.

## Test plan
- **Reset/single port:** NumPorts=3. Port 1 requests payload 0xA5 at cycle 0 → `port_ack_o`=3'b010 at cycle 0; `mem_req_o`=1, `mem_data_o`=0xA5, `mem_port_o`=1 at cycle 1; `idle_o` falls at cycle 1.
- **Round-robin fairness:** all 3 ports held requesting, `mem_ack_i`=1 → grant order 0,1,2,0,1,2, one per cycle. With `WT_MEM_ARB_FIXED_PRIO_EN` defined → port 0 every cycle.
- **Backpressure:** `mem_ack_i`=0 for 5 cycles → slot payload and tag stable, no further `port_ack_o`. Raising `mem_ack_i` → next grant in the same cycle.
- **Outstanding limit:** MaxOutstanding=2, no returns. Port 0 gets 2 acks, then stalls while port 1 is still granted. A return tagged 0 → port 0 is eligible the following cycle.
- **Simultaneous grant and return:** `cnt[0]`=1; grant to 0 and return to 0 in the same cycle → `port_rtrn_vld_o[0]`=1, `cnt[0]` stays 1.
- **Error:** return with tag 3 (NumPorts=3), or to a port with `cnt`=0 → no strobe, `err_o`=1 next cycle and stays high until `rst_ni` is low.
